// File: rtl/sprite_pos_regs.sv
// Double-buffered sprite position registers behind an Avalon-MM slave; the shadow bank commits to
// the active bank on a vsync frame edge. Optional build macro SPRITE_READBACK_EN enables shadow/CTRL readback.
module sprite_pos_regs (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [3:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        vsync_n,
    output logic [39:0] sprite_x,
    output logic [39:0] sprite_y,
    output logic        irq
);

    localparam int unsigned NUM_SPRITES = 5;
    localparam int unsigned NUM_REGS    = 2 * NUM_SPRITES;
    localparam int unsigned POS_W       = 8;
    localparam int unsigned FC_W        = 16;

    localparam logic [3:0] ADDR_CTRL    = 4'd10;
    localparam logic [3:0] ADDR_STATUS  = 4'd11;
    localparam logic [3:0] ADDR_IRQ_CLR = 4'd12;

    // Index 2i = X, 2i+1 = Y for sprite i (dino, jump, duck, s_cac, godzilla).
    localparam logic [NUM_REGS-1:0][POS_W-1:0] RESET_POS = {
        8'd4,   8'd100,
        8'd100, 8'd244,
        8'd200, 8'd44,
        8'd150, 8'd200,
        8'd100, 8'd100
    };

    logic [NUM_REGS-1:0][POS_W-1:0] shadow_q;
    logic [NUM_REGS-1:0][POS_W-1:0] active_q;
    logic                           auto_en;
    logic                           commit_req;
    logic                           pending;
    logic [FC_W-1:0]                frame_count;
    logic                           vs_q;

    logic        wr_en;
    logic        rd_en;
    logic        frame_edge;
    logic        shadow_wr;
    logic        ctrl_wr;
    logic        irq_clr_wr;
    logic        commit_req_eff;
    logic        commit;
    logic [31:0] rdata_next;

    // Bus decode and commit decision; a CTRL COMMIT write counts at a coincident frame edge.
    always_comb begin
        wr_en          = chipselect & write;
        rd_en          = chipselect & read;
        frame_edge     = vs_q & ~vsync_n;
        shadow_wr      = wr_en & (address < ADDR_CTRL);
        ctrl_wr        = wr_en & (address == ADDR_CTRL);
        irq_clr_wr     = wr_en & (address == ADDR_IRQ_CLR);
        commit_req_eff = commit_req | (ctrl_wr & writedata[1]);
        commit         = frame_edge & pending & (auto_en | commit_req_eff);
    end

    // Read mux; returns zero whenever no read is in progress.
    always_comb begin
        rdata_next = '0;
        if (rd_en) begin
            if (address == ADDR_STATUS) begin
                rdata_next = {frame_count, 14'd0, irq, pending};
            end
`ifdef SPRITE_READBACK_EN
            else if (address == ADDR_CTRL) begin
                rdata_next = {31'd0, auto_en};
            end else if (address < ADDR_CTRL) begin
                rdata_next = 32'(shadow_q[address]);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q    <= RESET_POS;
            active_q    <= RESET_POS;
            auto_en     <= 1'b1;
            commit_req  <= 1'b0;
            pending     <= 1'b0;
            irq         <= 1'b0;
            frame_count <= '0;
            vs_q        <= 1'b1;
            readdata    <= '0;
        end else begin
            vs_q     <= vsync_n;
            readdata <= rdata_next;
            if (frame_edge) begin
                frame_count <= frame_count + 16'd1;
            end
            if (shadow_wr) begin
                shadow_q[address] <= writedata[POS_W-1:0];
            end
            // Active bank samples the pre-write shadow, so a same-cycle write stays pending.
            if (commit) begin
                active_q <= shadow_q;
            end
            if (ctrl_wr) begin
                auto_en <= writedata[0];
            end
            commit_req <= commit ? 1'b0 : commit_req_eff;
            pending    <= shadow_wr | (pending & ~commit);
            if (commit) begin
                irq <= 1'b1;
            end else if (irq_clr_wr) begin
                irq <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_pack
        assign sprite_x[g*POS_W +: POS_W] = active_q[2*g];
        assign sprite_y[g*POS_W +: POS_W] = active_q[2*g+1];
    end

endmodule

// File: tb/tb_sprite_pos_regs.sv
// Randomized bench for sprite_pos_regs with an array-based reference model and directed literal checks.
module tb_sprite_pos_regs;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [3:0]  address = 4'd0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        vsync_n = 1'b1;
    logic [39:0] sprite_x;
    logic [39:0] sprite_y;
    logic        irq;

    sprite_pos_regs dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .vsync_n    (vsync_n),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 1'b0;

    int unsigned rst_x [5] = '{100, 200, 44, 244, 100};
    int unsigned rst_y [5] = '{100, 150, 200, 100, 4};

    logic [7:0]  m_sh  [10];
    logic [7:0]  m_act [10];
    logic        m_auto, m_creq, m_pend, m_irq, m_prev_vs;
    int unsigned m_frames;
    logic [31:0] m_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_sh[2*i]    = 8'(rst_x[i]);
            m_sh[2*i+1]  = 8'(rst_y[i]);
            m_act[2*i]   = 8'(rst_x[i]);
            m_act[2*i+1] = 8'(rst_y[i]);
        end
        m_auto = 1'b1; m_creq = 1'b0; m_pend = 1'b0; m_irq = 1'b0;
        m_frames = 0; m_prev_vs = 1'b1; m_rd = 32'd0;
    endtask

    // One clock of behaviour, all decisions taken from the state before the edge.
    task automatic model_step();
        bit wr, rd, frame, req, do_commit;
        logic [31:0] rd_new;
        wr = chipselect && write;
        rd = chipselect && read;
        frame = m_prev_vs && !vsync_n;
        req = m_creq || (wr && address == 4'd10 && writedata[1]);
        do_commit = frame && m_pend && (m_auto || req);
        rd_new = 32'd0;
        if (rd) begin
            if (address == 4'd11) rd_new = {16'(m_frames % 65536), 14'd0, m_irq, m_pend};
`ifdef SPRITE_READBACK_EN
            else if (address == 4'd10) rd_new = {31'd0, m_auto};
            else if (address < 4'd10) rd_new = {24'd0, m_sh[address]};
`endif
        end
        m_rd = rd_new;
        if (do_commit) for (int i = 0; i < 10; i++) m_act[i] = m_sh[i];
        if (wr && address < 4'd10) begin
            m_sh[address] = writedata[7:0];
            m_pend = 1'b1;
        end else if (do_commit) begin
            m_pend = 1'b0;
        end
        m_creq = do_commit ? 1'b0 : req;
        if (wr && address == 4'd10) m_auto = writedata[0];
        if (do_commit) m_irq = 1'b1;
        else if (wr && address == 4'd12) m_irq = 1'b0;
        if (frame) m_frames = m_frames + 1;
        m_prev_vs = vsync_n;
    endtask

    function automatic logic [39:0] pack_pos(input int base);
        logic [39:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) r[8*i +: 8] = m_act[2*i+base];
        return r;
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            chk("model_sprite_x", 64'(sprite_x), 64'(pack_pos(0)));
            chk("model_sprite_y", 64'(sprite_y), 64'(pack_pos(1)));
            chk("model_irq",      64'(irq),      64'(m_irq));
            chk("model_readdata", 64'(readdata), 64'(m_rd));
        end
    end

    task automatic cycle();
        @(posedge clk);
        if (reset) model_step();
        else model_reset();
        @(negedge clk);
    endtask

    task automatic idle();
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        cycle();
        idle();
    endtask

    task automatic bus_read(input logic [3:0] a);
        chipselect = 1'b1; read = 1'b1; address = a;
        cycle();
        idle();
    endtask

    task automatic frame();
        vsync_n = 1'b1;
        cycle();
        vsync_n = 1'b0;
        cycle();
        vsync_n = 1'b1;
    endtask

    task automatic async_reset();
        idle();
        #2 reset = 1'b0;
        #1 model_reset();
        chk("async_rst_x", 64'(sprite_x), 64'h64F42CC864);
        chk("async_rst_y", 64'(sprite_y), 64'h0464C89664);
        chk("async_rst_irq", 64'(irq), 64'd0);
        vsync_n = 1'b1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [31:0] exp_rb;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        checking = 1'b1;
        reset = 1'b1;
        chk("rst_sprite_x", 64'(sprite_x), 64'h64F42CC864);
        chk("rst_sprite_y", 64'(sprite_y), 64'h0464C89664);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_readdata", 64'(readdata), 64'd0);

        // Shadow write held until a frame edge under AUTO.
        bus_write(4'd0, 32'h37);
        repeat (100) cycle();
        chk("hold_x0", 64'(sprite_x[7:0]), 64'd100);
        bus_read(4'd11);
        chk("pending_set", 64'(readdata[0]), 64'd1);
        vsync_n = 1'b0;
        cycle();
        vsync_n = 1'b1;
        chk("commit_x0", 64'(sprite_x[7:0]), 64'h37);
        chk("commit_irq", 64'(irq), 64'd1);

        // Manual commit with AUTO off.
        bus_write(4'd10, 32'h0);
        bus_write(4'd3, 32'h10);
        frame();
        frame();
        chk("no_auto_commit", 64'(sprite_y[15:8]), 64'h96);
        bus_write(4'd10, 32'h2);
        frame();
        chk("manual_commit", 64'(sprite_y[15:8]), 64'h10);
        bus_read(4'd11);
        chk("pending_clear", 64'(readdata[0]), 64'd0);
        bus_write(4'd3, 32'h22);
        frame();
        chk("commit_req_consumed", 64'(sprite_y[15:8]), 64'h10);

        // Shadow write coinciding with a commit.
        bus_write(4'd10, 32'h1);
        bus_write(4'd8, 32'h20);
        vsync_n = 1'b0;
        chipselect = 1'b1; write = 1'b1; address = 4'd8; writedata = 32'h55;
        cycle();
        idle();
        vsync_n = 1'b1;
        chk("coincident_active", 64'(sprite_x[39:32]), 64'h20);
        chk("coincident_y3", 64'(sprite_y[15:8]), 64'h22);
        bus_read(4'd11);
        chk("coincident_pending", 64'(readdata[0]), 64'd1);
        frame();
        chk("next_edge_active", 64'(sprite_x[39:32]), 64'h55);

        // IRQ_CLR loses against a simultaneous commit.
        bus_write(4'd12, 32'h0);
        chk("irq_cleared", 64'(irq), 64'd0);
        bus_write(4'd1, 32'h11);
        vsync_n = 1'b0;
        chipselect = 1'b1; write = 1'b1; address = 4'd12; writedata = 32'h0;
        cycle();
        idle();
        vsync_n = 1'b1;
        chk("irq_set_wins", 64'(irq), 64'd1);
        bus_write(4'd12, 32'hFFFF_FFFF);
        chk("irq_clear_again", 64'(irq), 64'd0);

`ifdef SPRITE_READBACK_EN
        exp_rb = 32'h37;
`else
        exp_rb = 32'h0;
`endif
        bus_read(4'd0);
        chk("read_addr0", 64'(readdata), 64'(exp_rb));
        bus_read(4'd14);
        chk("read_unmapped", 64'(readdata), 64'd0);
        cycle();
        chk("readdata_idle", 64'(readdata), 64'd0);

        // Reset right after a commit edge wipes everything back.
        bus_write(4'd5, 32'h99);
        vsync_n = 1'b0;
        cycle();
        async_reset();
        repeat (300) frame();
        bus_read(4'd11);
        chk("frame_count_300", 64'(readdata), 64'h012C_0000);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) async_reset();
            chipselect = ($urandom % 4) != 0;
            write      = $urandom % 2;
            read       = $urandom % 2;
            address    = 4'($urandom_range(0, 15));
            writedata  = $urandom;
            vsync_n    = ($urandom % 6) != 0;
            cycle();
        end
        idle();
        vsync_n = 1'b1;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
